mustang_light_sequencer: RTL and testbench
==========================================

Name: mustang_light_sequencer

Overview:
Controller that sequences the Mustang tail-light display. Takes the raw left/right/hazard requests and the vsync from the VGA timer, and steps a 3-lamp-per-side pattern once every FRAMES_PER_STEP frames. Outputs registered lamp states that the bit generator paints. Sits between the user inputs and the pixel generator, in the same clk domain as the VGA timer.

Parameters:
FRAMES_PER_STEP, 8, number of video frames each pattern step is held; legal range 1..(2**CNT_W)-1
CNT_W, 4, width of the frame counter
VSYNC_ACTIVE_LOW, 1, 1 means the vsync pulse is low-true; 0 means high-true

Ports:
clk  in  1  system clock, same clock as the VGA timer
clear  in  1  asynchronous active-low reset
left  in  1  left-turn request, asynchronous level
right  in  1  right-turn request, asynchronous level
haz  in  1  hazard request, asynchronous level
vsync  in  1  vsync from the VGA timer, synchronous to clk
left_lamps  out  3  left lamp states; bit0 innermost, bit2 outermost
right_lamps  out  3  right lamp states; bit0 innermost, bit2 outermost
mode  out  2  current mode: 0 IDLE, 1 LEFT, 2 RIGHT, 3 HAZ
step  out  2  current pattern step, 0..3
step_tick  out  1  one-cycle pulse on every step evaluation

Behaviour:
- Reset (clear=0, async): all outputs 0, mode IDLE, frame counter 0, all sync/edge flops 0. Release is applied on clk.
- Input conditioning:
  - left, right and haz each pass through 2-flop synchronizers.
  - Requests are only consumed at evaluation points. This gives per-frame debounce.
- frame_tick:
  - Registered 1-cycle pulse, asserted the cycle after vsync is sampled making its active-going edge (vsync_prev inactive, vsync active).
  - vsync held active produces exactly one tick.
- Frame counter:
  - In an active mode, counts frame_ticks 0..FRAMES_PER_STEP-1.
  - A frame_tick at the terminal count asserts step_tick and wraps the counter to 0.
  - In IDLE, step_tick = frame_tick and the counter is held at 0.
- Request decode (synchronized values): haz=1 or (left=1 and right=1) -> HAZ; else left -> LEFT; else right -> RIGHT; else IDLE.
- Evaluation on each step_tick, registered on that clk edge:
  - Decoded mode differs from current mode and is non-IDLE: mode <= decoded, step <= 1, frame counter <= 0.
  - Decoded mode equals current mode and is non-IDLE: step advances 1->2->3->0->1… (wraps modulo 4).
  - Decoded mode is IDLE: mode <= IDLE, step <= 0 immediately, even mid-sequence.
- Lamp decode (registered with mode/step): step0=000, step1=001, step2=011, step3=111.
  - LEFT: left_lamps=pattern, right_lamps=000.
  - RIGHT: right_lamps=pattern, left_lamps=000.
  - HAZ: both sides show the same pattern in lockstep.
  - IDLE: both 000.
- Latency:
  - Request to sync: 2 clk.
  - vsync active edge sample to frame_tick: 1 clk.
  - frame_tick/step_tick to lamp update: 1 clk.
- Simultaneous events:
  - A request change with no step_tick is ignored until the next evaluation.
  - haz has priority over left and right.
  - left and right together is treated as HAZ.
- FRAMES_PER_STEP=1: every frame_tick is a step_tick.
- Reset mid-sequence: lamps go to 0 asynchronously. After release, the sequence restarts from IDLE on the first frame_tick that sees a request.
- No X on outputs after reset regardless of inputs.

Decomposition:
- Shared package (light_pkg):
  - Mode encodings MODE_IDLE/LEFT/RIGHT/HAZ (2-bit).
  - Lamp pattern constants LAMP_S0..LAMP_S3.
  - Step width constant.
- Sub-module vga_frame_ticker:
  - Contains vsync polarity normalization, edge detect, and the frame divider.
  - Outputs frame_tick and step_tick.
  - Takes a hold_zero input, asserted in IDLE.
- Top module contains the synchronizers, the mode/step FSM and the lamp decode.

Test Plan:
- Reset: clear=0 with left=1 and vsync toggling -> all outputs 0, no step_tick. Release -> lamps stay 000 until the first frame_tick.
- Left sequence, FRAMES_PER_STEP=2, left held: left_lamps go 001,011,111,000,001 every 2 frames. right_lamps stay 000. mode=1.
- Hazard: haz=1 with left=1 -> mode=3; left_lamps == right_lamps every cycle, stepping 001,011,111,000.
- Mid-sequence switch: left at step 2 (011), then right asserted and left dropped -> at the next step_tick mode=2, right_lamps=001, left_lamps=000.
- Release and short pulse:
  - left dropped at step 3 -> next step_tick gives lamps 000, mode=0.
  - A 1-frame left pulse between step_ticks while active is ignored.
- vsync held active for 3 frames' worth of cycles -> exactly one frame_tick. Async reset asserted mid-step -> outputs 0 in the same cycle, with no clk edge required.

Source files
------------

// File: rtl/light_pkg.sv
// Shared encodings for the Mustang tail-light sequencer: modes, lamp patterns,
// request bit positions and the request/lamp decode helpers.
package light_pkg;

    localparam int unsigned STEP_W = 2;
    localparam int unsigned LAMP_W = 3;
    localparam int unsigned MODE_W = 2;
    localparam int unsigned REQ_W  = 3;

    // Bit positions inside the packed {haz, right, left} request vector.
    localparam int unsigned REQ_LEFT  = 0;
    localparam int unsigned REQ_RIGHT = 1;
    localparam int unsigned REQ_HAZ   = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_IDLE  = 2'd0,
        MODE_LEFT  = 2'd1,
        MODE_RIGHT = 2'd2,
        MODE_HAZ   = 2'd3
    } mode_e;

    localparam logic [LAMP_W-1:0] LAMP_S0 = 3'b000;
    localparam logic [LAMP_W-1:0] LAMP_S1 = 3'b001;
    localparam logic [LAMP_W-1:0] LAMP_S2 = 3'b011;
    localparam logic [LAMP_W-1:0] LAMP_S3 = 3'b111;

    // Lamps fill from the innermost bit outward as the step advances.
    function automatic logic [LAMP_W-1:0] lamp_pattern(input logic [STEP_W-1:0] s);
        logic [LAMP_W-1:0] pat;
        case (s)
            2'd0:    pat = LAMP_S0;
            2'd1:    pat = LAMP_S1;
            2'd2:    pat = LAMP_S2;
            default: pat = LAMP_S3;
        endcase
        return pat;
    endfunction

    // Hazard wins; both turn signals together also means hazard.
    function automatic mode_e decode_request(input logic [REQ_W-1:0] req);
        mode_e m;
        if (req[REQ_HAZ] || (req[REQ_LEFT] && req[REQ_RIGHT])) begin
            m = MODE_HAZ;
        end else if (req[REQ_LEFT]) begin
            m = MODE_LEFT;
        end else if (req[REQ_RIGHT]) begin
            m = MODE_RIGHT;
        end else begin
            m = MODE_IDLE;
        end
        return m;
    endfunction

endpackage

// File: rtl/vga_frame_ticker.sv
// Turns the VGA vsync into a one-cycle frame tick and divides frames down into
// step ticks; the divider is parked at zero while the sequencer is idle.
module vga_frame_ticker #(
    parameter int unsigned FRAMES_PER_STEP  = 8,
    parameter int unsigned CNT_W            = 4,
    parameter int unsigned VSYNC_ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync_i,
    input  logic hold_zero_i,
    output logic frame_tick_o,
    output logic step_tick_o
);

    localparam bit               VS_LOW   = (VSYNC_ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

    logic             vs_act;
    logic             vs_prev_q;
    logic             frame_tick_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_last;
    logic             step_tick;

    assign vs_act = VS_LOW ? ~vsync_i : vsync_i;

    // Edge detect on the normalised (active-high) vsync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev_q    <= 1'b0;
            frame_tick_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            vs_prev_q    <= vs_act;
            frame_tick_q <= vs_act & ~vs_prev_q;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        at_last   = (cnt_q == CNT_LAST);
        step_tick = frame_tick_q & (hold_zero_i | at_last);
        if (hold_zero_i) begin
            cnt_d = '0;
        end else if (frame_tick_q) begin
            cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign frame_tick_o = frame_tick_q;
    assign step_tick_o  = step_tick;

endmodule

// File: rtl/mustang_light_sequencer.sv
// Mustang tail-light sequencer: synchronises the turn/hazard requests, runs the
// mode/step state machine on each step tick and registers the lamp outputs.
module mustang_light_sequencer
    import light_pkg::*;
#(
    parameter int unsigned FRAMES_PER_STEP  = 8,
    parameter int unsigned CNT_W            = 4,
    parameter int unsigned VSYNC_ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              left,
    input  logic              right,
    input  logic              haz,
    input  logic              vsync,
    output logic [LAMP_W-1:0] left_lamps,
    output logic [LAMP_W-1:0] right_lamps,
    output logic [MODE_W-1:0] mode,
    output logic [STEP_W-1:0] step,
    output logic              step_tick
);

    logic [REQ_W-1:0]  req_meta_q;
    logic [REQ_W-1:0]  req_sync_q;
    mode_e             req_mode;

    mode_e             mode_q;
    mode_e             mode_d;
    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] step_d;
    logic [LAMP_W-1:0] left_lamps_q;
    logic [LAMP_W-1:0] left_lamps_d;
    logic [LAMP_W-1:0] right_lamps_q;
    logic [LAMP_W-1:0] right_lamps_d;
    logic [LAMP_W-1:0] pattern;

    logic              hold_zero;
    logic              frame_tick;
    logic              step_tick_w;
    logic              eval_en;

    // Two-flop synchronisers for the asynchronous request levels.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            req_meta_q <= '0;
            req_sync_q <= '0;
        end else begin
            req_meta_q <= {haz, right, left};
            req_sync_q <= req_meta_q;
        end
    end

    assign hold_zero = (mode_q == MODE_IDLE);

    vga_frame_ticker #(
        .FRAMES_PER_STEP  (FRAMES_PER_STEP),
        .CNT_W            (CNT_W),
        .VSYNC_ACTIVE_LOW (VSYNC_ACTIVE_LOW)
    ) u_ticker (
        .clk          (clk),
        .rst_n        (clear),
        .vsync_i      (vsync),
        .hold_zero_i  (hold_zero),
        .frame_tick_o (frame_tick),
        .step_tick_o  (step_tick_w)
    );

    // A step tick only ever coincides with a frame tick.
    assign eval_en   = step_tick_w & frame_tick;
    assign step_tick = step_tick_w;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            mode_q        <= MODE_IDLE;
            step_q        <= '0;
            left_lamps_q  <= LAMP_S0;
            right_lamps_q <= LAMP_S0;
        end else begin
            mode_q        <= mode_d;
            step_q        <= step_d;
            left_lamps_q  <= left_lamps_d;
            right_lamps_q <= right_lamps_d;
        end
    end

    // Requests are consumed only at evaluation points; lamps follow the next state.
    always_comb begin
        mode_d   = mode_q;
        step_d   = step_q;
        req_mode = decode_request(req_sync_q);
        if (eval_en) begin
            if (req_mode == MODE_IDLE) begin
                mode_d = MODE_IDLE;
                step_d = '0;
            end else if (req_mode != mode_q) begin
                mode_d = req_mode;
                step_d = STEP_W'(1);
            end else begin
                step_d = step_q + STEP_W'(1);
            end
        end
        pattern       = lamp_pattern(step_d);
        left_lamps_d  = ((mode_d == MODE_LEFT)  || (mode_d == MODE_HAZ)) ? pattern : LAMP_S0;
        right_lamps_d = ((mode_d == MODE_RIGHT) || (mode_d == MODE_HAZ)) ? pattern : LAMP_S0;
    end

    assign left_lamps  = left_lamps_q;
    assign right_lamps = right_lamps_q;
    assign mode        = mode_q;
    assign step        = step_q;

endmodule

// File: tb/tb_mustang_light_sequencer.sv
// Bench for the tail-light sequencer: two instances (2 frames/step low-true vsync,
// 1 frame/step high-true vsync) checked every cycle against a behavioural model.
module tb_mustang_light_sequencer;

    logic clk    = 1'b0;
    logic clear  = 1'b1;
    logic left   = 1'b0;
    logic right  = 1'b0;
    logic haz    = 1'b0;
    logic vs_act = 1'b0;
    logic vsync0;
    logic vsync1;

    logic [2:0] ll0, rl0, ll1, rl1;
    logic [1:0] mode0, step0, mode1, step1;
    logic       st0, st1;

    assign vsync0 = ~vs_act;
    assign vsync1 = vs_act;

    always #5 clk = ~clk;

    mustang_light_sequencer #(.FRAMES_PER_STEP(2), .CNT_W(4), .VSYNC_ACTIVE_LOW(1)) dut0 (
        .clk(clk), .clear(clear), .left(left), .right(right), .haz(haz), .vsync(vsync0),
        .left_lamps(ll0), .right_lamps(rl0), .mode(mode0), .step(step0), .step_tick(st0));

    mustang_light_sequencer #(.FRAMES_PER_STEP(1), .CNT_W(4), .VSYNC_ACTIVE_LOW(0)) dut1 (
        .clk(clk), .clear(clear), .left(left), .right(right), .haz(haz), .vsync(vsync1),
        .left_lamps(ll1), .right_lamps(rl1), .mode(mode1), .step(step1), .step_tick(st1));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int   fps [2] = '{2, 1};
    int   m_mode [2];
    int   m_step [2];
    int   m_frames [2];
    logic [2:0] r1, r2;        // request samples one and two edges back {haz,right,left}
    logic v_prev;
    logic pend;                // a frame edge was seen, evaluation happens next edge

    function automatic int decode(input logic [2:0] r);
        if (r[2] || (r[0] && r[1])) return 3;
        if (r[0]) return 1;
        if (r[1]) return 2;
        return 0;
    endfunction

    always @(posedge clk or negedge clear) begin
        int  d;
        bit  tick;
        if (!clear) begin
            r1 = 3'b000; r2 = 3'b000; v_prev = 1'b0; pend = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_mode[i] = 0; m_step[i] = 0; m_frames[i] = 0;
            end
        end else begin
            d = decode(r2);
            for (int i = 0; i < 2; i++) begin
                if (pend) begin
                    tick = (m_mode[i] == 0) || (m_frames[i] == fps[i] - 1);
                    if (m_mode[i] == 0 || tick) m_frames[i] = 0;
                    else m_frames[i] = m_frames[i] + 1;
                    if (tick) begin
                        if (d == 0) begin
                            m_mode[i] = 0; m_step[i] = 0;
                        end else if (d != m_mode[i]) begin
                            m_mode[i] = d; m_step[i] = 1;
                        end else begin
                            m_step[i] = (m_step[i] + 1) % 4;
                        end
                    end
                end
            end
            pend   = vs_act && !v_prev;
            v_prev = vs_act;
            r2     = r1;
            r1     = {haz, right, left};
        end
    end

    task automatic cmp_dut(input int i, input logic [2:0] ll, input logic [2:0] rl,
                           input logic [1:0] md, input logic [1:0] sp, input logic st);
        int pat, exp_l, exp_r, exp_st;
        pat    = (1 << m_step[i]) - 1;
        exp_l  = (m_mode[i] == 1 || m_mode[i] == 3) ? pat : 0;
        exp_r  = (m_mode[i] == 2 || m_mode[i] == 3) ? pat : 0;
        exp_st = (pend && (m_mode[i] == 0 || m_frames[i] == fps[i] - 1)) ? 1 : 0;
        chk($sformatf("dut%0d mode", i), int'(md), m_mode[i]);
        chk($sformatf("dut%0d step", i), int'(sp), m_step[i]);
        chk($sformatf("dut%0d left_lamps", i), int'(ll), exp_l);
        chk($sformatf("dut%0d right_lamps", i), int'(rl), exp_r);
        chk($sformatf("dut%0d step_tick", i), int'(st), exp_st);
    endtask

    always @(negedge clk) begin
        cmp_dut(0, ll0, rl0, mode0, step0, st0);
        cmp_dut(1, ll1, rl1, mode1, step1, st1);
    end

    // ---------------- stimulus ----------------
    logic [2:0] seq0 [9] = '{3'd1, 3'd1, 3'd3, 3'd3, 3'd7, 3'd7, 3'd0, 3'd0, 3'd1};
    logic [2:0] seq1 [9] = '{3'd1, 3'd3, 3'd7, 3'd0, 3'd1, 3'd3, 3'd7, 3'd0, 3'd1};

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input int act_len, input int len);
        @(negedge clk);
        vs_act = 1'b1;
        repeat (act_len) @(negedge clk);
        vs_act = 1'b0;
        repeat (len - act_len) @(negedge clk);
    endtask

    initial begin
        int ticks;
        int len, al;
        #1 clear = 1'b0;

        // Reset held with a request and vsync activity.
        left = 1'b1;
        repeat (3) frame(1, 4);
        chk("reset left_lamps", int'(ll0), 0);
        chk("reset mode", int'(mode1), 0);

        // Release: lamps stay dark until the first frame tick.
        @(negedge clk) clear = 1'b1;
        cycles(3);
        chk("post-release lamps", int'(ll0), 0);
        for (int f = 0; f < 9; f++) begin
            frame(1, 4);
            chk($sformatf("left seq dut0 f%0d", f), int'(ll0), int'(seq0[f]));
            chk($sformatf("left seq dut1 f%0d", f), int'(ll1), int'(seq1[f]));
        end
        chk("left seq right_lamps", int'(rl0), 0);
        chk("left seq mode", int'(mode0), 1);

        // Hazard with left still held.
        haz = 1'b1;
        cycles(3);
        frame(1, 4);
        chk("haz f10 dut0 still left", int'(mode0), 1);
        frame(1, 4);
        chk("haz mode", int'(mode0), 3);
        chk("haz left", int'(ll0), 1);
        chk("haz right", int'(rl0), 1);
        frame(1, 4);
        frame(1, 4);
        chk("haz step2 left", int'(ll0), 3);
        chk("haz step2 right", int'(rl0), 3);

        // Back to left, then switch to right at step 2.
        haz = 1'b0;
        repeat (4) frame(1, 4);
        chk("left again step2", int'(ll0), 3);
        left = 1'b0; right = 1'b1;
        cycles(3);
        frame(1, 4);
        chk("switch pending", int'(ll0), 3);
        frame(1, 4);
        chk("switch mode", int'(mode0), 2);
        chk("switch right", int'(rl0), 1);
        chk("switch left", int'(ll0), 0);

        // Release at step 3.
        repeat (4) frame(1, 4);
        chk("right step3", int'(rl0), 7);
        right = 1'b0;
        cycles(3);
        repeat (2) frame(1, 4);
        chk("release lamps", int'(rl0), 0);
        chk("release mode", int'(mode0), 0);

        // Short drop of left between step ticks is not seen.
        left = 1'b1;
        cycles(3);
        frame(1, 4);
        chk("pulse start", int'(ll0), 1);
        frame(1, 2);
        left = 1'b0;
        cycles(3);
        left = 1'b1;
        cycles(3);
        frame(1, 4);
        chk("pulse ignored lamps", int'(ll0), 3);
        chk("pulse ignored mode", int'(mode0), 1);

        // vsync held active: exactly one frame tick.
        cycles(4);
        ticks = 0;
        vs_act = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (st1) ticks++;
        end
        vs_act = 1'b0;
        chk("vsync held ticks", ticks, 1);
        cycles(4);

        // Asynchronous reset mid-step, checked before any clock edge.
        chk("pre-reset lamps nonzero", (ll0 != 3'd0) ? 1 : 0, 1);
        #2 clear = 1'b0;
        #1;
        chk("async rst left0", int'(ll0), 0);
        chk("async rst mode0", int'(mode0), 0);
        chk("async rst step0", int'(step0), 0);
        chk("async rst left1", int'(ll1), 0);
        @(negedge clk);
        @(negedge clk) clear = 1'b1;

        // Randomised frames with random requests and occasional resets.
        for (int f = 0; f < 300; f++) begin
            len = $urandom_range(3, 10);
            al  = $urandom_range(1, len - 1);
            if ($urandom_range(0, 2) == 0) begin
                left  = 1'($urandom_range(0, 1));
                right = 1'($urandom_range(0, 1));
                haz   = ($urandom_range(0, 5) == 0);
            end
            @(negedge clk);
            vs_act = 1'b1;
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                if (c == al - 1) vs_act = 1'b0;
                if ($urandom_range(0, 9) == 0) left = ~left;
            end
            if ($urandom_range(0, 39) == 0) begin
                #2 clear = 1'b0;
                @(negedge clk);
                @(negedge clk) clear = 1'b1;
            end
        end

        cycles(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
